// File: rtl/fc_mac_engine_pkg.sv
// Shared types and helpers for the fully-connected MAC engine.
package fc_pkg;

    // Scratch width for the saturating shift; must exceed any accumulator width in use.
    localparam int MAX_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_ARGMAX,
        ST_DONE
    } fc_state_e;

    // Accumulator width that can hold N_IN worst-case products plus a bias without overflow.
    function automatic int acc_width(input int data_w, input int weight_w, input int n_in);
        return data_w + weight_w + $clog2(n_in) + 1;
    endfunction

    // Index width with a floor of one bit so single-entry ranges still get a real signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic right shift followed by clamping to a signed out_w-bit range.
    function automatic logic signed [MAX_W-1:0] sat_shift(
        input logic signed [MAX_W-1:0] a,
        input int                      shift,
        input int                      out_w
    );
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        s  = a >>> shift;
        hi = {{(MAX_W-1){1'b0}}, 1'b1} <<< (out_w - 1);
        hi = hi - MAX_W'(1);
        lo = -hi - MAX_W'(1);
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fc_mac_engine_if.sv
// Feature stream, weight memory, bias and result bundle for fc_mac_engine.
interface fc_mac_engine_if
    import fc_pkg::*;
#(
    parameter int N_IN     = 1152,
    parameter int N_OUT    = 10,
    parameter int DATA_W   = 69,
    parameter int WEIGHT_W = 32,
    parameter int OUT_W    = 32
) ();
    localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, N_IN);
    localparam int ADDR_W = idx_width(N_IN);
    localparam int IDX_W  = idx_width(N_OUT);

    logic                      start;
    logic [N_OUT*ACC_W-1:0]    bias;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      w_rd_en;
    logic [ADDR_W-1:0]         w_addr;
    logic [N_OUT*WEIGHT_W-1:0] w_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*OUT_W-1:0]    out_result;
    logic [IDX_W-1:0]          out_argmax;

    // Environment side: feature source, weight memory and result sink.
    modport master (
        output start, bias, in_valid, in_data, w_rdata, out_ready,
        input  in_ready, w_rd_en, w_addr, out_valid, out_result, out_argmax
    );

    // Engine side.
    modport slave (
        input  start, bias, in_valid, in_data, w_rdata, out_ready,
        output in_ready, w_rd_en, w_addr, out_valid, out_result, out_argmax
    );

endinterface

// File: rtl/fc_mac_lane.sv
// One class accumulator: loads a bias, then adds feature*weight products.
module fc_mac_lane #(
    parameter int DATA_W   = 69,
    parameter int WEIGHT_W = 32,
    parameter int ACC_W    = 113
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic signed [ACC_W-1:0]    load_val,
    input  logic                       acc_en,
    input  logic [DATA_W-1:0]          feature,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [ACC_W-1:0]    acc
);
    localparam int PROD_W = DATA_W + WEIGHT_W + 1;

    logic signed [PROD_W-1:0] prod;

    // Feature is unsigned, so a zero sign bit is prepended before the signed multiply.
    always_comb begin
        prod = $signed({1'b0, feature}) * weight;
    end

    // Accumulator register: bias load takes priority over accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (acc_en) begin
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: streams N_IN features, MACs into N_OUT lanes,
// then scans the lanes to produce saturated scores and an argmax.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start; bias is loaded into the lanes on start
//   ST_LOAD    | accepting features, issuing weight reads
//   ST_DRAIN   | one cycle for the MAC of the last accepted feature
//   ST_ARGMAX  | one lane per cycle: saturate, store, track best score
//   ST_DONE    | results valid until out_ready
module fc_mac_engine
    import fc_pkg::*;
#(
    parameter int N_IN      = 1152,
    parameter int N_OUT     = 10,
    parameter int DATA_W    = 69,
    parameter int WEIGHT_W  = 32,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 69
) (
    input logic            clk,
    input logic            rst,
    fc_mac_engine_if.slave bus
);
    localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, N_IN);
    localparam int ADDR_W = idx_width(N_IN);
    localparam int IDX_W  = idx_width(N_OUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_OUT - 1);

    fc_state_e state_q;
    fc_state_e state_d;

    logic                    in_ready_c;
    logic                    accept;
    logic                    load_bias;
    logic [ADDR_W-1:0]       count_q;
    logic [DATA_W-1:0]       feat_q;
    logic                    mac_pend_q;
    logic [IDX_W-1:0]        scan_q;
    logic                    scan_last;
    logic signed [OUT_W-1:0] best_val_q;
    logic [IDX_W-1:0]        best_idx_q;
    logic signed [OUT_W-1:0] res_work_q [N_OUT];
    logic [N_OUT*OUT_W-1:0]  result_q;
    logic [IDX_W-1:0]        argmax_q;

    logic signed [ACC_W-1:0] acc [N_OUT];
    logic signed [ACC_W-1:0] acc_sel;
    logic signed [MAX_W-1:0] sat_full;
    logic signed [OUT_W-1:0] cur_val;
    logic                    take_cur;

    assign scan_last = (scan_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        load_bias  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load_bias = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (count_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                if (scan_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.w_rd_en    = accept;
    assign bus.w_addr     = count_q;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_argmax = argmax_q;

    // Weight data arrives the cycle after the read, so the MAC is one cycle behind the accept.
    genvar j;
    generate
        for (j = 0; j < N_OUT; j++) begin : g_lane
            fc_mac_lane #(
                .DATA_W  (DATA_W),
                .WEIGHT_W(WEIGHT_W),
                .ACC_W   (ACC_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load    (load_bias),
                .load_val(bus.bias[j*ACC_W +: ACC_W]),
                .acc_en  (mac_pend_q),
                .feature (feat_q),
                .weight  (bus.w_rdata[j*WEIGHT_W +: WEIGHT_W]),
                .acc     (acc[j])
            );
        end
    endgenerate

    // Saturated score of the lane under scan and whether it beats the best so far.
    always_comb begin
        acc_sel  = acc[scan_q];
        sat_full = sat_shift({{(MAX_W-ACC_W){acc_sel[ACC_W-1]}}, acc_sel}, OUT_SHIFT, OUT_W);
        cur_val  = sat_full[OUT_W-1:0];
        take_cur = (scan_q == '0) || (cur_val > best_val_q);
    end

    // Feature counter, feature capture and pending-MAC flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            feat_q     <= '0;
            mac_pend_q <= 1'b0;
        end else begin
            mac_pend_q <= accept;
            if (load_bias) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + ADDR_W'(1);
            end
            if (accept) begin
                feat_q <= bus.in_data;
            end
        end
    end

    // Argmax scan; published results only change on the final scan step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_q     <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            result_q   <= '0;
            argmax_q   <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                res_work_q[k] <= '0;
            end
        end else if (state_q == ST_DRAIN) begin
            scan_q <= '0;
        end else if (state_q == ST_ARGMAX) begin
            res_work_q[scan_q] <= cur_val;
            if (take_cur) begin
                best_val_q <= cur_val;
                best_idx_q <= scan_q;
            end
            if (scan_last) begin
                for (int k = 0; k < N_OUT; k++) begin
                    result_q[k*OUT_W +: OUT_W] <= (IDX_W'(k) == scan_q) ? cur_val : res_work_q[k];
                end
                argmax_q <= take_cur ? scan_q : best_idx_q;
            end else begin
                scan_q <= scan_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fc_mac_engine.sv
// Directed bench for fc_mac_engine with N_IN=4, N_OUT=3, 8-bit data/weights/results.
// A second instance with OUT_SHIFT=2 runs in lockstep on the same stimulus.
module tb_fc_mac_engine;
    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int OW    = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0]       feat_v [N_IN];
    logic [N_OUT*WW-1:0] wmem   [N_IN];

    always #5 clk = ~clk;

    fc_mac_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .WEIGHT_W(WW), .OUT_W(OW)) if0 ();
    fc_mac_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .WEIGHT_W(WW), .OUT_W(OW)) if1 ();

    fc_mac_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .WEIGHT_W(WW), .OUT_W(OW), .OUT_SHIFT(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    fc_mac_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .WEIGHT_W(WW), .OUT_W(OW), .OUT_SHIFT(2)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if1.start     = if0.start;
    assign if1.bias      = if0.bias;
    assign if1.in_valid  = if0.in_valid;
    assign if1.in_data   = if0.in_data;
    assign if1.out_ready = if0.out_ready;

    // Weight memory models: one-cycle read latency.
    always @(posedge clk) begin
        if (if0.w_rd_en) if0.w_rdata <= wmem[if0.w_addr];
        if (if1.w_rd_en) if1.w_rdata <= wmem[if1.w_addr];
    end

    function automatic int res0(input int j);
        return int'($signed(if0.out_result[j*OW +: OW]));
    endfunction

    task automatic set_weights(input int w0, input int w1, input int w2);
        for (int i = 0; i < N_IN; i++) wmem[i] = {8'(w2), 8'(w1), 8'(w0)};
    endtask

    task automatic start_pulse;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
    endtask

    task automatic feed_beats(input int n, input int gap_max, input bit chk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if0.in_valid = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            if0.in_valid = 1'b1;
            if0.in_data  = feat_v[i];
            #1;
            if (chk) begin
                checks++;
                if (if0.in_ready !== 1'b1) begin
                    errors++; $display("FAIL in_ready beat %0d: got %b expected 1", i, if0.in_ready);
                end
                checks++;
                if (if0.w_rd_en !== 1'b1) begin
                    errors++; $display("FAIL w_rd_en beat %0d: got %b expected 1", i, if0.w_rd_en);
                end
                checks++;
                if (if0.w_addr !== 2'(i)) begin
                    errors++; $display("FAIL w_addr beat %0d: got %0d expected %0d", i, if0.w_addr, i);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        if0.in_valid = 1'b0;
    endtask

    // Counts rising edges after the last accept until out_valid; gives up at 20.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if0.out_valid && lat < 20);
    endtask

    task automatic handshake;
        @(negedge clk); if0.out_ready = 1'b1;
        @(posedge clk); #1;
        if0.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", if0.out_valid); end
        checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", if0.in_ready); end
        checks++; if (if0.w_rd_en !== 1'b0) begin errors++; $display("FAIL reset w_rd_en: got %b expected 0", if0.w_rd_en); end
        checks++; if (if0.out_result !== 24'h0) begin errors++; $display("FAIL reset out_result: got %h expected 000000", if0.out_result); end
        checks++; if (if0.out_argmax !== 2'd0) begin errors++; $display("FAIL reset out_argmax: got %0d expected 0", if0.out_argmax); end
    endtask

    task automatic test_basic(input string tag);
        int lat;
        set_weights(1, -1, 2);
        if0.bias = '0;
        feat_v[0] = 8'd1; feat_v[1] = 8'd2; feat_v[2] = 8'd3; feat_v[3] = 8'd4;
        start_pulse();
        feed_beats(4, 0, 1'b1);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL %s latency: got %0d expected 4", tag, lat); end
        checks++; if (res0(0) !== 10) begin errors++; $display("FAIL %s class0: got %0d expected 10", tag, res0(0)); end
        checks++; if (res0(1) !== -10) begin errors++; $display("FAIL %s class1: got %0d expected -10", tag, res0(1)); end
        checks++; if (res0(2) !== 20) begin errors++; $display("FAIL %s class2: got %0d expected 20", tag, res0(2)); end
        checks++; if (if0.out_argmax !== 2'd2) begin errors++; $display("FAIL %s argmax: got %0d expected 2", tag, if0.out_argmax); end
        handshake();
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid after handshake: got %b expected 0", tag, if0.out_valid); end
    endtask

    task automatic test_saturate;
        int lat;
        set_weights(127, -128, 0);
        if0.bias = '0;
        for (int i = 0; i < N_IN; i++) feat_v[i] = 8'd255;
        start_pulse();
        feed_beats(4, 0, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sat latency: got %0d expected 4", lat); end
        checks++; if (res0(0) !== 127) begin errors++; $display("FAIL sat class0: got %0d expected 127", res0(0)); end
        checks++; if (res0(1) !== -128) begin errors++; $display("FAIL sat class1: got %0d expected -128", res0(1)); end
        checks++; if (res0(2) !== 0) begin errors++; $display("FAIL sat class2: got %0d expected 0", res0(2)); end
        checks++; if (if0.out_argmax !== 2'd0) begin errors++; $display("FAIL sat argmax: got %0d expected 0", if0.out_argmax); end
        handshake();
    endtask

    task automatic test_tie;
        int lat;
        set_weights(0, 0, 0);
        if0.bias = {19'sd5, 19'sd5, 19'sd5};
        feat_v[0] = 8'd9; feat_v[1] = 8'd200; feat_v[2] = 8'd33; feat_v[3] = 8'd7;
        start_pulse();
        feed_beats(4, 0, 1'b0);
        wait_done(lat);
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL tie out_valid: got %b expected 1", if0.out_valid); end
        checks++; if (if0.out_result !== {8'sd5, 8'sd5, 8'sd5}) begin errors++; $display("FAIL tie results: got %h expected 050505", if0.out_result); end
        checks++; if (if0.out_argmax !== 2'd0) begin errors++; $display("FAIL tie argmax: got %0d expected 0", if0.out_argmax); end
        handshake();
    endtask

    task automatic test_gaps_hold;
        int lat;
        set_weights(1, -1, 2);
        if0.bias = '0;
        feat_v[0] = 8'd1; feat_v[1] = 8'd2; feat_v[2] = 8'd3; feat_v[3] = 8'd4;
        start_pulse();
        feed_beats(4, 3, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL gaps latency: got %0d expected 4", lat); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if0.start = (c >= 3 && c <= 5);
            @(posedge clk); #1;
            checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL hold out_valid cycle %0d: got %b expected 1", c, if0.out_valid); end
            checks++; if (if0.out_result !== {8'sd20, -8'sd10, 8'sd10}) begin errors++; $display("FAIL hold results cycle %0d: got %h expected 14f60a", c, if0.out_result); end
            checks++; if (if0.out_argmax !== 2'd2) begin errors++; $display("FAIL hold argmax cycle %0d: got %0d expected 2", c, if0.out_argmax); end
        end
        @(negedge clk); if0.start = 1'b0;
        handshake();
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL gaps out_valid after handshake: got %b expected 0", if0.out_valid); end
        checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL gaps start not ignored, in_ready: got %b expected 0", if0.in_ready); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if0.out_result !== {8'sd20, -8'sd10, 8'sd10}) begin errors++; $display("FAIL retain results: got %h expected 14f60a", if0.out_result); end
        checks++; if (if0.out_argmax !== 2'd2) begin errors++; $display("FAIL retain argmax: got %0d expected 2", if0.out_argmax); end
    endtask

    task automatic test_reset_mid;
        set_weights(1, -1, 2);
        if0.bias = '0;
        feat_v[0] = 8'd1; feat_v[1] = 8'd2; feat_v[2] = 8'd3; feat_v[3] = 8'd4;
        start_pulse();
        feed_beats(2, 0, 1'b0);
        @(posedge clk); #1;
        if0.in_valid = 1'b1;
        rst = 1'b0;
        #1;
        checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL midrst in_ready: got %b expected 0", if0.in_ready); end
        checks++; if (if0.w_rd_en !== 1'b0) begin errors++; $display("FAIL midrst w_rd_en: got %b expected 0", if0.w_rd_en); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid: got %b expected 0", if0.out_valid); end
        checks++; if (if0.out_result !== 24'h0) begin errors++; $display("FAIL midrst out_result: got %h expected 000000", if0.out_result); end
        checks++; if (if0.out_argmax !== 2'd0) begin errors++; $display("FAIL midrst out_argmax: got %0d expected 0", if0.out_argmax); end
        if0.in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        test_basic("rerun");
    endtask

    task automatic test_shift;
        int lat;
        set_weights(0, 0, 0);
        if0.bias = {-19'sd5, -19'sd5, -19'sd5};
        feat_v[0] = 8'd17; feat_v[1] = 8'd0; feat_v[2] = 8'd99; feat_v[3] = 8'd250;
        start_pulse();
        feed_beats(4, 0, 1'b0);
        wait_done(lat);
        checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL shift out_valid: got %b expected 1", if1.out_valid); end
        checks++; if (if0.out_result !== {-8'sd5, -8'sd5, -8'sd5}) begin errors++; $display("FAIL noshift results: got %h expected fbfbfb", if0.out_result); end
        checks++; if (if1.out_result !== {-8'sd2, -8'sd2, -8'sd2}) begin errors++; $display("FAIL shift2 results: got %h expected fefefe", if1.out_result); end
        checks++; if (if1.out_argmax !== 2'd0) begin errors++; $display("FAIL shift2 argmax: got %0d expected 0", if1.out_argmax); end
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        if0.start     = 1'b0;
        if0.bias      = '0;
        if0.in_valid  = 1'b0;
        if0.in_data   = '0;
        if0.out_ready = 1'b0;
        set_weights(0, 0, 0);
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk); rst = 1'b1;
        test_basic("basic");
        test_saturate();
        test_tie();
        test_gaps_hold();
        test_reset_mid();
        test_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
